mips_trace_buffer: RTL and testbench

Instruction-trace capture stage placed directly downstream of `mips_processor`. It consumes the processor's `pc_out` and `alu_result` each cycle and records one entry per distinct PC into a circular buffer. It supports a PC-match trigger with post-trigger depth and a valid/ready readout port for a bench or debug host. It replaces ad-hoc `$display` tracing with synthesizable, back-pressured trace data.

---
 rtl/mips_trace_buffer.sv | 172 +++++++++++++++++
 tb/tb_mips_trace_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_buffer.sv
// Per-PC instruction trace buffer with PC-match trigger and a show-ahead valid/ready dump port.
// Capture takes one cycle to reach count_o. Readout holds each head until accepted. Timestamps: MIPS_TRACE_TIMESTAMP_EN.
module mips_trace_buffer #(
  parameter int PC_WIDTH   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic [DATA_WIDTH-1:0]  alu_in,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   trig_en,
  input  logic [PC_WIDTH-1:0]    trig_pc,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [PC_WIDTH-1:0]    rd_pc,
  output logic [DATA_WIDTH-1:0]  rd_alu,
`ifdef MIPS_TRACE_TIMESTAMP_EN
  output logic [15:0]            rd_time,
`endif
  output logic [1:0]             state_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] POST_LOAD = CW'(POST_TRIG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DUMP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] alu;
`ifdef MIPS_TRACE_TIMESTAMP_EN
    logic [15:0]           ts;
`endif
  } entry_t;

  entry_t              mem [DEPTH];
  entry_t              wr_entry;
  entry_t              head;
  state_t              state;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       post_cnt;
  logic                first;
  logic [PC_WIDTH-1:0] last_pc;
  logic                capturing;
  logic                wr_en;
  logic                full;
  logic                trig_hit;

`ifdef MIPS_TRACE_TIMESTAMP_EN
  logic [15:0] ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (arm) begin
      ts <= '0;
    end else begin
      ts <= ts + 16'd1;
    end
  end
`endif

  // arm suppresses the write: a restart discards anything sampled on that edge
  assign capturing = (state == S_ARMED) || (state == S_POST);
  assign wr_en     = capturing && !arm && (first || (pc_in != last_pc));
  assign full      = (count == FULL_CNT);
  assign trig_hit  = (state == S_ARMED) && wr_en && trig_en && (pc_in == trig_pc);

  always_comb begin
    wr_entry     = '0;
    wr_entry.pc  = pc_in;
    wr_entry.alu = alu_in;
`ifdef MIPS_TRACE_TIMESTAMP_EN
    wr_entry.ts  = ts;
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_cnt <= '0;
      overflow <= 1'b0;
      first    <= 1'b0;
      last_pc  <= '0;
    end else if (arm) begin
      state    <= S_ARMED;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_cnt <= '0;
      overflow <= 1'b0;
      first    <= 1'b1;
    end else begin
      case (state)
        S_ARMED, S_POST: begin
          if (wr_en) begin
            first   <= 1'b0;
            last_pc <= pc_in;
            wr_ptr  <= wr_ptr + 1'b1;
            // full buffer: drop the oldest entry by moving the read side along
            if (full) begin
              rd_ptr   <= rd_ptr + 1'b1;
              overflow <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
          if (stop) begin
            state <= S_DUMP;
          end else if (state == S_ARMED) begin
            if (trig_hit) begin
              post_cnt <= POST_LOAD;
              state    <= (POST_TRIG == 0) ? S_DUMP : S_POST;
            end
          end else if (wr_en) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == CW'(1)) begin
              state <= S_DUMP;
            end
          end
        end
        S_DUMP: begin
          if (count == '0) begin
            state <= S_IDLE;
          end else if (rd_ready) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
            if (count == CW'(1)) begin
              state <= S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign rd_valid = (state == S_DUMP) && (count != '0);
  assign rd_pc    = rd_valid ? head.pc  : '0;
  assign rd_alu   = rd_valid ? head.alu : '0;
`ifdef MIPS_TRACE_TIMESTAMP_EN
  assign rd_time  = rd_valid ? head.ts  : '0;
`endif
  assign state_o  = state;
  assign count_o  = count;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: queue-based reference model compared every cycle, directed scenarios plus random traffic.
module tb_mips_trace_buffer;
  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] pc_in = '0;
  logic [15:0] alu_in = '0;
  logic        arm = 1'b0;
  logic        stop = 1'b0;
  logic        trig_en = 1'b0;
  logic [15:0] trig_pc = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_pc;
  logic [15:0] rd_alu;
  logic [1:0]  state_o;
  logic [4:0]  count_o;
  logic        overflow;
`ifdef MIPS_TRACE_TIMESTAMP_EN
  logic [15:0] rd_time;
`endif

  mips_trace_buffer #(
    .PC_WIDTH(16), .DATA_WIDTH(16), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .alu_in(alu_in),
    .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_alu(rd_alu),
`ifdef MIPS_TRACE_TIMESTAMP_EN
    .rd_time(rd_time),
`endif
    .state_o(state_o), .count_o(count_o), .overflow(overflow)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] alu;
    logic [15:0] ts;
  } ent_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the trace is a queue of entries, oldest at the front
  ent_t        m_q[$];
  int          m_state = 0;
  logic        m_ovf = 1'b0;
  logic        m_first = 1'b0;
  logic [15:0] m_last = '0;
  int          m_post = 0;
  logic [15:0] m_time = '0;

  task automatic model_reset();
    m_q.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_first = 1'b0;
    m_last  = '0;
    m_post  = 0;
    m_time  = '0;
  endtask

  task automatic model_step();
    ent_t e;
    logic w;
    e.pc  = pc_in;
    e.alu = alu_in;
    e.ts  = m_time;
    m_time = arm ? 16'd0 : m_time + 16'd1;
    if (arm) begin
      m_state = 1;
      m_q.delete();
      m_ovf   = 1'b0;
      m_first = 1'b1;
    end else if (m_state == 1 || m_state == 2) begin
      w = m_first || (pc_in != m_last);
      if (w) begin
        if (m_q.size() == DEPTH) begin
          m_q.delete(0);
          m_ovf = 1'b1;
        end
        m_q.push_back(e);
        m_first = 1'b0;
        m_last  = pc_in;
      end
      if (stop) m_state = 3;
      else if (m_state == 1) begin
        if (w && trig_en && pc_in == trig_pc) begin
          m_post  = POST_TRIG;
          m_state = (POST_TRIG == 0) ? 3 : 2;
        end
      end else if (w) begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
    end else if (m_state == 3) begin
      if (m_q.size() == 0) m_state = 0;
      else if (rd_ready) begin
        m_q.delete(0);
        if (m_q.size() == 0) m_state = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  ent_t        log_q[$];
  logic        hold = 1'b0;
  logic [15:0] hold_pc, hold_alu;

  // Compare process: DUT vs model on every falling edge, plus accepted-entry log
  initial forever begin
    logic        mv;
    logic [15:0] epc, ealu, ets;
    ent_t        got;
    @(negedge clk);
    mv   = (m_state == 3) && (m_q.size() > 0);
    epc  = mv ? m_q[0].pc  : 16'd0;
    ealu = mv ? m_q[0].alu : 16'd0;
    ets  = mv ? m_q[0].ts  : 16'd0;
    chk("state", state_o, m_state);
    chk("count", count_o, m_q.size());
    chk("overflow", overflow, m_ovf);
    chk("rd_valid", rd_valid, mv);
    chk("rd_pc", rd_pc, epc);
    chk("rd_alu", rd_alu, ealu);
`ifdef MIPS_TRACE_TIMESTAMP_EN
    chk("rd_time", rd_time, ets);
`endif
    if (rst_n && hold) begin
      chk("hold_valid", rd_valid, 1);
      chk("hold_pc", rd_pc, hold_pc);
      chk("hold_alu", rd_alu, hold_alu);
    end
    hold     = rst_n && rd_valid && !rd_ready && !arm;
    hold_pc  = rd_pc;
    hold_alu = rd_alu;
    if (rst_n && rd_valid && rd_ready && !arm) begin
      got.pc  = rd_pc;
      got.alu = rd_alu;
`ifdef MIPS_TRACE_TIMESTAMP_EN
      got.ts  = rd_time;
`else
      got.ts  = 16'd0;
`endif
      log_q.push_back(got);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic [3:0] pat);
    log_q.delete();
    for (int k = 0; k < 300; k++) begin
      rd_ready = pat[k % 4];
      cyc();
      if (state_o == 2'd0) break;
    end
    rd_ready = 1'b0;
    chk("drain_idle", state_o, 0);
  endtask

  task automatic run_basic(input logic [3:0] pat);
    arm = 1'b1; pc_in = 16'd0; alu_in = 16'd100;
    cyc();
    arm = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pc_in = 16'(2 * i); alu_in = 16'(2 * i + 100);
      cyc(); cyc();
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("basic_state_dump", state_o, 3);
    chk("basic_count", count_o, 6);
    chk("basic_overflow", overflow, 0);
    chk("basic_first_pc", rd_pc, 0);
    chk("basic_first_alu", rd_alu, 100);
    drain(pat);
    chk("basic_log_size", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      chk("basic_log_pc", log_q[i].pc, 2 * i);
      chk("basic_log_alu", log_q[i].alu, 2 * i + 100);
`ifdef MIPS_TRACE_TIMESTAMP_EN
      chk("basic_log_time", log_q[i].ts, 2 * i);
`endif
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cyc(); cyc();
    chk("reset_state", state_o, 0);
    chk("reset_count", count_o, 0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_pc", rd_pc, 0);
    rst_n = 1'b1;
    cyc();

    // Reset in the middle of POST
    trig_en = 1'b1; trig_pc = 16'd4;
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_in = 16'(2 * i); cyc();
    end
    chk("pre_reset_post", state_o, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_state", state_o, 0);
    chk("async_reset_count", count_o, 0);
    chk("async_reset_valid", rd_valid, 0);
    chk("async_reset_ovf", overflow, 0);
    cyc(); rst_n = 1'b1; trig_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc_in = 16'(40 + 2 * i); cyc();
    end
    chk("idle_no_capture_state", state_o, 0);
    chk("idle_no_capture_count", count_o, 0);

    run_basic(4'b1111);

    // Trigger with wrap
    trig_en = 1'b1; trig_pc = 16'd20;
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 30; i++) begin
      pc_in = 16'(2 * i); alu_in = 16'(i);
      cyc();
      if (2 * i == 20) chk("trig_to_post", state_o, 2);
      if (2 * i == 36) begin
        chk("trig_dump", state_o, 3);
        chk("trig_count", count_o, 16);
        chk("trig_overflow", overflow, 1);
        break;
      end
    end
    trig_en = 1'b0;
    drain(4'b1111);
    chk("trig_log_size", log_q.size(), 16);
    for (int k = 0; k < 16 && k < log_q.size(); k++)
      chk("trig_log_pc", log_q[k].pc, 6 + 2 * k);

    // Backpressure: ready pattern 1,0,0,1
    run_basic(4'b1001);

    // Restart during DUMP with a simultaneous pop
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_in = 16'(2 * i); alu_in = 16'(2 * i + 1); cyc();
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("restart_pre_count", count_o, 4);
    rd_ready = 1'b1; arm = 1'b1; pc_in = 16'd50; alu_in = 16'd150;
    cyc();
    arm = 1'b0; rd_ready = 1'b0;
    chk("restart_state", state_o, 1);
    chk("restart_count", count_o, 0);
    chk("restart_ovf", overflow, 0);
    cyc();
    chk("restart_first_write", count_o, 1);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("restart_head_pc", rd_pc, 50);
    chk("restart_head_alu", rd_alu, 150);
    drain(4'b1111);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      arm      = ($urandom_range(0, 59) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      rd_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) pc_in = 16'(2 * $urandom_range(0, 15));
      alu_in = 16'($urandom);
      if (arm) begin
        trig_en = 1'($urandom_range(0, 1));
        trig_pc = 16'(2 * $urandom_range(0, 15));
      end
      cyc();
    end
    arm = 1'b0; stop = 1'b1; cyc(); stop = 1'b0;
    drain(4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
